// File: rtl/press_gen.sv
// Key-press waveform generator: turns one-cycle press requests into HOLD-high / GAP-low key
// pulses, buffering bursts in a saturating pending counter.
module press_gen #(
  parameter int unsigned HOLD   = 3,
  parameter int unsigned GAP    = 2,
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          key,
  output logic          busy,
  output logic [CW-1:0] pending,
  output logic          done,
  output logic          overflow
);

  localparam int unsigned MaxC = (HOLD > GAP) ? HOLD : GAP;
  localparam int unsigned CntW = (MaxC > 1) ? $clog2(MaxC) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   pend_q, pend_d;
  logic            key_q, key_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic hold_last, gap_last, have_pend, start, deq, enq;

  assign hold_last = (cnt_q == CntW'(HOLD - 1));
  assign gap_last  = (cnt_q == CntW'(GAP - 1));
  assign have_pend = (pend_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (have_pend || req) start = 1'b1;
      end
      StHold: begin
        if (hold_last) begin
          state_d = StGap;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_last) begin
          if (have_pend || req) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (start) begin
      state_d = StHold;
      cnt_d   = '0;
    end
  end

  // A start with an empty queue consumes req directly; otherwise req joins the queue.
  assign deq = start && have_pend;
  assign enq = req && !(start && !have_pend);

  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (enq && !deq) begin
      if (pend_q == CW'(QDEPTH)) ovf_d = 1'b1;
      else                       pend_d = pend_q + 1'b1;
    end else if (deq && !enq) begin
      pend_d = pend_q - 1'b1;
    end
    key_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      key_q   <= key_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key      = key_q;
  assign busy     = (state_q != StIdle);
  assign pending  = pend_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: doc/press_gen.md
Name: press_gen

Overview:
- Transmitter side of the key-press interface. Turns one-cycle press requests into clean key waveforms.
- Each press holds `key` high for a fixed number of cycles, then enforces a minimum low gap.
- Sits in front of the key-release pulse detector. Used as a computer/automated player and for loopback self-test of user-input paths.
- Buffers bursts of requests in a saturating pending counter.

Parameters:
- HOLD, 3: cycles `key` is held high per press; must be ≥1.
- GAP, 2: minimum cycles `key` is held low between presses; must be ≥1.
- QDEPTH, 4: maximum queued (not yet started) requests.
- CW, $clog2(QDEPTH+1): width of the pending count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  1  press request; each cycle high is one request.
- key  output  1  generated key level, registered.
- busy  output  1  high whenever the FSM is not IDLE.
- pending  output  CW  requests queued and not yet started.
- done  output  1  registered one-cycle pulse, first cycle `key` is low after a press.
- overflow  output  1  registered one-cycle pulse, request dropped because the queue is full.

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, key=0, pending=0, done=0, overflow=0, cycle counter=0.
  - Applies from any state, including mid-HOLD: `key` falls at that edge and no `done` is issued.
- FSM states: IDLE, HOLD, GAP. `key` = 1 only in HOLD. busy = (state != IDLE).
- IDLE:
  - If pending>0, go to HOLD and decrement pending.
  - Otherwise, if req, go to HOLD and consume req directly (not queued).
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N with an empty queue gives key=1 from edge N onward (first high cycle is N+1).
- HOLD: stays exactly HOLD cycles. On the last HOLD cycle, go to GAP; done=1 for the first GAP cycle only.
- GAP: stays exactly GAP cycles. On the last GAP cycle:
  - If pending>0 or req, go directly to HOLD, consuming as in IDLE.
  - Otherwise go to IDLE.
  - Press period under continuous load = HOLD+GAP cycles.
- Queueing: req arriving when not consumed that cycle increments pending.
  - req while pending==QDEPTH and no dequeue that cycle: request dropped, pending stays QDEPTH, overflow=1 next cycle.
  - Simultaneous req and dequeue: pending unchanged, no overflow, including when pending==QDEPTH.
  - pending never exceeds QDEPTH and never wraps below 0.
- Cycle counter:
  - Loads 0 on each state entry.
  - Width holds max(HOLD,GAP)-1.
  - No wrap-around inside a state.
- done and overflow are never high for more than one consecutive cycle per event. Both are 0 during reset.
- A req during the reset cycle is ignored.

Test Plan (defaults HOLD=3, GAP=2, QDEPTH=4):
1. Reset: rst=0 for 4 edges with req toggling -> key=0, busy=0, pending=0, done=0, overflow=0 throughout.
2. Single request: rst=1, req=1 at edge N only ->
   - key=1 for cycles N+1..N+3, key=0 at N+4.
   - done=1 only in cycle N+4.
   - busy=1 for N+1..N+5, busy=0 from N+6.
   - pending stays 0.
3. Burst of 3: req high at edges N, N+1, N+2 ->
   - pending goes 1, 2 and then drains.
   - key rising cycles N+1, N+6, N+11; three done pulses.
   - idle at N+16.
4. Overflow: req high for 6 consecutive edges starting at N ->
   - first request starts directly; pending reaches 4.
   - sixth request dropped, overflow=1 single cycle at N+6.
   - exactly 5 presses total.
5. Reset mid-operation: rst=0 during 2nd HOLD cycle with pending=2 ->
   - key=0 the next cycle, pending=0, state IDLE.
   - no done, no further presses.
6. Loopback: key drives the key-release pulse detector; send 4 requests -> detector emits exactly 4 one-cycle pulses, each one cycle after key falls.
